karatsuba_divider_seq: RTL and testbench
========================================

Name: karatsuba_divider_seq

Overview:
- Sequential radix-2 restoring divider; the inverse operation of the Karatsuba_N multiplier.
- Takes a 2N-bit dividend (e.g. a Karatsuba product) and an N-bit divisor; returns a 2N-bit quotient and an N-bit remainder.
- Sits beside the multiplier in the arithmetic datapath: self-check path (product / b == a) and general division.
- valid/ready handshake on both input and output sides.

Parameters:
- N, 32, divisor width; dividend and quotient are 2N bits; legal range N >= 2.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands on dividend/divisor are valid.
- in_ready  output  1  divider can accept operands.
- dividend  input  2N  unsigned dividend.
- divisor  input  N  unsigned divisor.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  2N  unsigned quotient.
- remainder  output  N  unsigned remainder.
- div_by_zero  output  1  the result came from a zero divisor.

Behaviour:
- Reset (async assert, rst_n low): state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- States:
  - IDLE: in_ready=1.
  - CALC: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> CALC: on an edge with in_valid&&in_ready and divisor!=0. Latch the dividend into the quotient/shift register and the divisor into an internal register. Clear the (N+1)-bit partial remainder. Counter=0.
- IDLE -> DONE (zero divisor): on the accepting edge with divisor==0, go directly to DONE.
  - quotient={2N{1'b1}}, remainder=0, div_by_zero=1.
  - Latency: 1 edge.
- CALC, one iteration per edge:
  - Shift {rem, q} left by 1. The q MSB enters rem.
  - If the shifted rem >= divisor: rem -= divisor and q LSB=1; otherwise q LSB=0.
  - Counter increments each edge. After iteration 2N (counter==2N-1 at that edge) go to DONE.
- Latency: the accept edge is k. out_valid rises after edge k+2N and is visible in the cycle after it. Latency is fixed, independent of operand values.
- DONE: quotient/remainder/div_by_zero are held stable while out_valid=1 and out_ready=0 (backpressure, unbounded).
- DONE -> IDLE: on an edge with out_valid&&out_ready.
  - out_valid drops and in_ready rises on the next cycle.
  - No same-cycle restart: a new operand is accepted no earlier than the cycle after the output handshake. Throughput is one op per 2N+2 cycles minimum.
- Outputs quotient/remainder may be don't-care while out_valid=0. The implementation keeps the last result; the bench must not check them when out_valid=0.
- div_by_zero is cleared on the next accept.
- Invariant for every non-zero divisor: quotient*divisor+remainder == dividend, and remainder < divisor.
- Dividend/divisor changes while in CALC/DONE are ignored (operands are latched).
- in_valid held high in CALC/DONE: no acceptance until IDLE.
- Reset mid-operation: returns immediately to reset values; the in-flight result is discarded; no spurious out_valid after release.
- No X propagation: every register has a reset value.

Test Plan:
- N=8: dividend=16'd1000, divisor=8'd7, out_ready=1 → after 16 cycles: out_valid=1, quotient=16'd142, remainder=8'd6, div_by_zero=0.
- N=8: dividend=16'hFFFF, divisor=8'h01 → quotient=16'hFFFF, remainder=0. Then dividend=16'h00FE, divisor=8'hFF → quotient=0, remainder=8'hFE.
- N=8: divisor=0, dividend=16'h1234 → out_valid one cycle after accept, quotient=16'hFFFF, remainder=0, div_by_zero=1. The next op with divisor=3, dividend=9 gives quotient=3, remainder=0, div_by_zero=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid → outputs and out_valid are stable, in_ready=0, and in_valid pulses are ignored. Raising out_ready → one handshake, then in_ready=1 the next cycle.
- Reset mid-op: assert rst_n=0 at iteration 5 of 16 → all outputs at reset values immediately, in_ready=1 after release, no out_valid. The next op, 100/10, gives quotient=10, remainder=0.
- Round trip, N=32, 200 random pairs: dividend=Karatsuba_0(a,b) output, divisor=b (b!=0) → quotient==a, remainder==0. Plus random dividend/divisor pairs checked against the invariant and the reference quotient from `/` and `%`.

Source files
------------

// File: rtl/karatsuba_divider_seq_if.sv
// Handshake bundle for karatsuba_divider_seq.
// master: operand producer / result consumer; slave: the divider.
interface karatsuba_divider_seq_if #(
   parameter int N = 32
);
   logic           in_valid;
   logic           in_ready;
   logic [2*N-1:0] dividend;
   logic [N-1:0]   divisor;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] quotient;
   logic [N-1:0]   remainder;
   logic           div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/karatsuba_divider_seq.sv
// Sequential radix-2 restoring divider: 2N-bit dividend / N-bit divisor.
// Ports: clk, rst_n (async low), bus (slave: in/out valid-ready, operands, results).
module karatsuba_divider_seq #(
   parameter int N = 32
) (
   input logic                    clk,
   input logic                    rst_n,
   karatsuba_divider_seq_if.slave bus
);
   localparam int W  = 2 * N;
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [N-1:0]   rem;
   logic [W-1:0]   q;
   logic [N-1:0]   dsr;
   logic           in_ready_r;
   logic           out_valid_r;
   logic [W-1:0]   quo_r;
   logic [N-1:0]   rem_r;
   logic           dbz_r;

   // Partial remainder stays below the divisor between steps, so only the
   // shifted value needs the extra bit, and the difference fits in N bits.
   logic [N:0]     sh;
   logic           ge;
   logic [N-1:0]   rem_n;
   logic [W-1:0]   q_n;

   always_comb begin
      sh    = {rem, q[W-1]};
      ge    = (sh >= {1'b0, dsr});
      rem_n = ge ? (sh[N-1:0] - dsr) : sh[N-1:0];
      q_n   = {q[W-2:0], ge};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         rem         <= '0;
         q           <= '0;
         dsr         <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         quo_r       <= '0;
         rem_r       <= '0;
         dbz_r       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  in_ready_r <= 1'b0;
                  if (bus.divisor == '0) begin
                     quo_r       <= '1;
                     rem_r       <= '0;
                     dbz_r       <= 1'b1;
                     out_valid_r <= 1'b1;
                     state       <= DONE;
                  end else begin
                     q     <= bus.dividend;
                     dsr   <= bus.divisor;
                     rem   <= '0;
                     cnt   <= '0;
                     dbz_r <= 1'b0;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               q   <= q_n;
               rem <= rem_n;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  quo_r       <= q_n;
                  rem_r       <= rem_n;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.quotient    = quo_r;
   assign bus.remainder   = rem_r;
   assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_karatsuba_divider_seq.sv
// Bench for karatsuba_divider_seq: N=8 directed cases and N=32 round trips.
// Expected results are queued at drive time and popped at the output handshake.
module tb_karatsuba_divider_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   passed = 0;
   int   total = 0;

   typedef struct {
      logic [63:0] q;
      logic [31:0] r;
      logic        dbz;
   } exp_t;

   exp_t sb[$];

   karatsuba_divider_seq_if #(.N(8))  b8 ();
   karatsuba_divider_seq_if #(.N(32)) b32 ();

   karatsuba_divider_seq #(.N(8)) u8 (
      .clk(clk), .rst_n(rst_n), .bus(b8)
   );
   karatsuba_divider_seq #(.N(32)) u32 (
      .clk(clk), .rst_n(rst_n), .bus(b32)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] o,
                      input logic [63:0] e);
      total++;
      assert (o === e) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
   endtask

   task automatic op8(input logic [15:0] dvd, input logic [7:0] dsr,
                      input int hold);
      exp_t e;
      int   lat;
      e.q   = (dsr == 0) ? 64'hFFFF : 64'(dvd / dsr);
      e.r   = (dsr == 0) ? 32'd0 : 32'(dvd % dsr);
      e.dbz = (dsr == 0);
      sb.push_back(e);
      b8.out_ready = (hold == 0);
      b8.dividend  = dvd;
      b8.divisor   = dsr;
      b8.in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b8.in_valid = 1'b0;
      lat = 0;
      while (!b8.out_valid && lat < 100) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      chk("lat8", 64'(lat), (dsr == 0) ? 64'd0 : 64'd16);
      chk("busy8", 64'(b8.in_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         chk("hold_ov", 64'(b8.out_valid), 64'd1);
         chk("hold_q", 64'(b8.quotient), sb[0].q);
         chk("hold_r", 64'(b8.remainder), 64'(sb[0].r));
         chk("hold_ir", 64'(b8.in_ready), 64'd0);
         b8.in_valid = i[0];
         b8.dividend = 16'($urandom);
         b8.divisor  = 8'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      b8.in_valid  = 1'b0;
      b8.out_ready = 1'b1;
      e = sb.pop_front();
      chk("q8", 64'(b8.quotient), e.q);
      chk("r8", 64'(b8.remainder), 64'(e.r));
      chk("dbz8", 64'(b8.div_by_zero), 64'(e.dbz));
      @(posedge clk);
      @(negedge clk);
      chk("post_ov8", 64'(b8.out_valid), 64'd0);
      chk("post_ir8", 64'(b8.in_ready), 64'd1);
   endtask

   task automatic op32(input logic [63:0] dvd, input logic [31:0] dsr);
      exp_t e;
      int   lat;
      e.q   = dvd / 64'(dsr);
      e.r   = 32'(dvd % 64'(dsr));
      e.dbz = 1'b0;
      sb.push_back(e);
      b32.out_ready = 1'b1;
      b32.dividend  = dvd;
      b32.divisor   = dsr;
      b32.in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b32.in_valid = 1'b0;
      lat = 0;
      while (!b32.out_valid && lat < 200) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      chk("lat32", 64'(lat), 64'd64);
      e = sb.pop_front();
      chk("q32", b32.quotient, e.q);
      chk("r32", 64'(b32.remainder), 64'(e.r));
      chk("inv32",
          64'((128'(b32.quotient) * 128'(dsr) + 128'(b32.remainder))
              == 128'(dvd)), 64'd1);
      chk("rlt32", 64'(b32.remainder < dsr), 64'd1);
      @(posedge clk);
      @(negedge clk);
      chk("post_ir32", 64'(b32.in_ready), 64'd1);
   endtask

   initial begin
      int          bad;
      logic [31:0] a;
      logic [31:0] b;
      b8.in_valid   = 1'b0;
      b8.out_ready  = 1'b1;
      b8.dividend   = '0;
      b8.divisor    = '0;
      b32.in_valid  = 1'b0;
      b32.out_ready = 1'b1;
      b32.dividend  = '0;
      b32.divisor   = '0;

      repeat (3) @(negedge clk);
      chk("rst_ir", 64'(b8.in_ready), 64'd1);
      chk("rst_ov", 64'(b8.out_valid), 64'd0);
      chk("rst_q", 64'(b8.quotient), 64'd0);
      chk("rst_r", 64'(b8.remainder), 64'd0);
      chk("rst_dbz", 64'(b8.div_by_zero), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      op8(16'd1000, 8'd7, 0);
      op8(16'hFFFF, 8'h01, 0);
      op8(16'h00FE, 8'hFF, 0);
      op8(16'h1234, 8'h00, 0);
      op8(16'd9, 8'd3, 0);
      op8(16'd200, 8'd9, 10);
      op8(16'd0, 8'd5, 0);

      b8.dividend = 16'd50000;
      b8.divisor  = 8'd123;
      b8.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b8.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_ir", 64'(b8.in_ready), 64'd1);
      chk("mid_ov", 64'(b8.out_valid), 64'd0);
      chk("mid_q", 64'(b8.quotient), 64'd0);
      chk("mid_r", 64'(b8.remainder), 64'd0);
      chk("mid_dbz", 64'(b8.div_by_zero), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (b8.out_valid) bad++;
      end
      chk("no_spurious", 64'(bad), 64'd0);
      op8(16'd100, 8'd10, 0);

      for (int i = 0; i < 200; i++) begin
         a = $urandom;
         b = $urandom;
         if (b == 0) b = 32'd1;
         sb.push_back('{q: 64'(a), r: 32'd0, dbz: 1'b0});
         op32(64'(a) * 64'(b), b);
         void'(sb.pop_front());
      end
      for (int i = 0; i < 40; i++) begin
         b = (i < 20) ? 32'($urandom_range(255, 1)) : $urandom;
         if (b == 0) b = 32'd7;
         op32({$urandom, $urandom}, b);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
